// File: rtl/rf_wb_arbiter_pkg.sv
// Shared register-file definitions for the write-back path: geometry,
// data-width helper, source-check enable bit positions and a decode helper.
package rf_wb_arbiter_pkg;

    localparam int RF_ADDR_W = 3;
    localparam int RF_DEPTH  = 8;
    localparam int DOMAIN_W  = 8;

    // Bit positions inside chk_en for the three source operands.
    localparam int CHK_EN_SRC1 = 0;
    localparam int CHK_EN_SRC2 = 1;
    localparam int CHK_EN_SRC3 = 2;

    // Register data width for a given number of residue domains.
    function automatic int rf_data_w(input int n_domains);
        return n_domains * DOMAIN_W;
    endfunction

    // One-hot decode of a register address onto the scoreboard width.
    function automatic logic [RF_DEPTH-1:0] reg_onehot(input logic [RF_ADDR_W-1:0] addr);
        return RF_DEPTH'(1) << addr;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first active request at or after
// the pointer, wrapping. The pointer moves past the winner only when the
// grant is actually consumed (advance strobe).
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] i_req,
    input  logic         i_advance,
    output logic [N-1:0] o_grant
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic [N-1:0]     w_hi_mask;
    logic [N-1:0]     w_req_hi;
    logic [N-1:0]     w_pick;

    // Requests at or above the pointer take priority; if there are none the
    // scan wraps to the lowest active request. Lowest set bit gives the winner.
    assign w_hi_mask = {N{1'b1}} << r_ptr;
    assign w_req_hi  = i_req & w_hi_mask;
    assign w_pick    = (|w_req_hi) ? w_req_hi : i_req;
    assign o_grant   = w_pick & (~w_pick + N'(1));

    // Next pointer is one past the current winner, modulo N.
    always_comb begin
        w_ptr_nxt = r_ptr;
        for (int i = 0; i < N; i++) begin
            if (o_grant[i]) begin
                w_ptr_nxt = (i == N - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    // Pointer register; holds when no grant is taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= w_ptr_nxt;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back controller: arbitrates write-back requesters onto
// the single RF write port, tracks pending destinations in a scoreboard and
// flags RAW/WAW hazards to the issue stage.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter  int NUM_DOMAINS = 1,
    parameter  int NUM_REQ     = 3,
    localparam int W           = rf_data_w(NUM_DOMAINS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [3*NUM_REQ-1:0]     req_addr,
    input  logic [W*NUM_REQ-1:0]     req_data,
    input  logic                     iss_valid,
    input  logic [RF_ADDR_W-1:0]     iss_addr,
    output logic                     iss_stall,
    input  logic [RF_ADDR_W-1:0]     chk_addr1,
    input  logic [RF_ADDR_W-1:0]     chk_addr2,
    input  logic [RF_ADDR_W-1:0]     chk_addr3,
    input  logic [2:0]               chk_en,
    output logic                     chk_hazard,
    output logic                     rf_wr_en,
    output logic [RF_ADDR_W-1:0]     rf_wr_addr,
    output logic [W-1:0]             rf_wr_data,
    output logic [RF_DEPTH-1:0]      pending,
    output logic                     wb_err
);

    logic                 r_wr_en;
    logic [RF_ADDR_W-1:0] r_wr_addr;
    logic [W-1:0]         r_wr_data;
    logic [RF_DEPTH-1:0]  r_pending;
    logic                 r_wb_err;

    logic [NUM_REQ-1:0]   w_grant;
    logic                 w_transfer;
    logic [RF_ADDR_W-1:0] w_sel_addr;
    logic [W-1:0]         w_sel_data;
    logic [RF_DEPTH-1:0]  w_clr_mask;
    logic [RF_DEPTH-1:0]  w_set_mask;
    logic [RF_DEPTH-1:0]  w_claimed;
    logic                 w_claim;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .clk       (clk),
        .reset     (reset),
        .i_req     (req_valid),
        .i_advance (w_transfer),
        .o_grant   (w_grant)
    );

    // Grant is only ever raised on a valid request, so any grant is a transfer.
    assign req_ready  = w_grant;
    assign w_transfer = |w_grant;

    // Mux the granted requester's address and data onto the write path.
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = req_addr[3*i +: 3];
                w_sel_data = req_data[W*i +: W];
            end
        end
    end

    // Sources are checked against the raw scoreboard: a register being
    // written back this very cycle still counts as pending (no bypass).
    assign chk_hazard = (chk_en[CHK_EN_SRC1] & r_pending[chk_addr1])
                      | (chk_en[CHK_EN_SRC2] & r_pending[chk_addr2])
                      | (chk_en[CHK_EN_SRC3] & r_pending[chk_addr3]);
    assign iss_stall  = iss_valid & (chk_hazard | r_pending[iss_addr]);
    assign w_claim    = iss_valid & ~iss_stall;

    assign w_clr_mask = r_wr_en ? reg_onehot(r_wr_addr) : '0;
    assign w_set_mask = w_claim ? reg_onehot(iss_addr)  : '0;
    // A register whose write-back is already in the output stage no longer
    // counts as claimed for a new transfer.
    assign w_claimed  = r_pending & ~w_clr_mask;

    // Output stage: one-cycle registered write; addr/data hold when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_transfer;
            if (w_transfer) begin
                r_wr_addr <= w_sel_addr;
                r_wr_data <= w_sel_data;
            end
        end
    end

    // Scoreboard: clear on write-back, set on claim; set wins on a collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
        end
    end

    // Sticky error for a write-back to a register nobody claimed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wb_err <= 1'b0;
        end else if (w_transfer && !w_claimed[w_sel_addr]) begin
            r_wb_err <= 1'b1;
        end
    end

    assign rf_wr_en   = r_wr_en;
    assign rf_wr_addr = r_wr_addr;
    assign rf_wr_data = r_wr_data;
    assign pending    = r_pending;
    assign wb_err     = r_wb_err;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with hand-computed expected values.
module tb_rf_wb_arbiter;

    localparam int NUM_REQ = 3;
    localparam int W       = 8;

    logic                 clk;
    logic                 reset;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [3*NUM_REQ-1:0] req_addr;
    logic [W*NUM_REQ-1:0] req_data;
    logic                 iss_valid;
    logic [2:0]           iss_addr;
    logic                 iss_stall;
    logic [2:0]           chk_addr1;
    logic [2:0]           chk_addr2;
    logic [2:0]           chk_addr3;
    logic [2:0]           chk_en;
    logic                 chk_hazard;
    logic                 rf_wr_en;
    logic [2:0]           rf_wr_addr;
    logic [W-1:0]         rf_wr_data;
    logic [7:0]           pending;
    logic                 wb_err;

    int n_vec = 0;
    int n_err = 0;

    rf_wb_arbiter #(
        .NUM_DOMAINS (1),
        .NUM_REQ     (NUM_REQ)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .iss_valid  (iss_valid),
        .iss_addr   (iss_addr),
        .iss_stall  (iss_stall),
        .chk_addr1  (chk_addr1),
        .chk_addr2  (chk_addr2),
        .chk_addr3  (chk_addr3),
        .chk_en     (chk_en),
        .chk_hazard (chk_hazard),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data),
        .pending    (pending),
        .wb_err     (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] a, input logic [7:0] d);
        req_addr[3*i +: 3] = a;
        req_data[W*i +: W] = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        iss_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        req_valid = '0;
        req_addr = '0;
        req_data = '0;
        iss_valid = 1'b0;
        iss_addr = '0;
        chk_addr1 = '0;
        chk_addr2 = '0;
        chk_addr3 = '0;
        chk_en = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        chk_val("rst_pending", 32'(pending), 32'h00);
        chk_val("rst_wr_en",   32'(rf_wr_en), 32'h0);
        chk_val("rst_wb_err",  32'(wb_err), 32'h0);
        chk_val("rst_ready",   32'(req_ready), 32'h0);

        // 1) reset mid-stream
        iss_valid = 1'b1; iss_addr = 3'd1;
        #1;
        chk_val("t1_iss_stall", 32'(iss_stall), 32'h0);
        tick();
        iss_valid = 1'b0;
        chk_val("t1_pending", 32'(pending), 32'h02);
        set_req(0, 3'd6, 8'h11);
        req_valid = 3'b001;
        #1;
        chk_val("t1_ready", 32'(req_ready), 32'h1);
        tick();
        chk_val("t1_wr_en",   32'(rf_wr_en), 32'h1);
        chk_val("t1_wr_data", 32'(rf_wr_data), 32'h11);
        chk_val("t1_wb_err",  32'(wb_err), 32'h1);
        reset = 1'b1;
        #1;
        chk_val("t1_rst_wr_en",   32'(rf_wr_en), 32'h0);
        chk_val("t1_rst_pending", 32'(pending), 32'h00);
        chk_val("t1_rst_wb_err",  32'(wb_err), 32'h0);
        chk_val("t1_rst_wr_data", 32'(rf_wr_data), 32'h00);
        req_valid = '0;
        tick();
        reset = 1'b0;
        tick();

        // 2) issue R3, req0 writes R3 = A5
        iss_valid = 1'b1; iss_addr = 3'd3;
        tick();
        iss_valid = 1'b0;
        chk_val("t2_pending_set", 32'(pending), 32'h08);
        set_req(0, 3'd3, 8'hA5);
        req_valid = 3'b001;
        tick();
        req_valid = '0;
        chk_val("t2_wr_en",   32'(rf_wr_en), 32'h1);
        chk_val("t2_wr_addr", 32'(rf_wr_addr), 32'h3);
        chk_val("t2_wr_data", 32'(rf_wr_data), 32'hA5);
        chk_val("t2_pending_hold", 32'(pending), 32'h08);
        chk_val("t2_wb_err",  32'(wb_err), 32'h0);
        tick();
        chk_val("t2_pending_clr", 32'(pending), 32'h00);
        chk_val("t2_idle_wr_en",  32'(rf_wr_en), 32'h0);
        chk_val("t2_hold_addr",   32'(rf_wr_addr), 32'h3);
        chk_val("t2_hold_data",   32'(rf_wr_data), 32'hA5);

        // 3) round robin, all three held valid
        do_reset();
        set_req(0, 3'd0, 8'h10);
        set_req(1, 3'd1, 8'h21);
        set_req(2, 3'd2, 8'h32);
        req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk_val($sformatf("t3_grant%0d", c), 32'(req_ready), 32'(1 << (c % 3)));
            tick();
            chk_val($sformatf("t3_addr%0d", c), 32'(rf_wr_addr), 32'(c % 3));
            chk_val($sformatf("t3_data%0d", c), 32'(rf_wr_data), 32'h10 + 32'h11 * 32'(c % 3));
        end
        req_valid = 3'b100;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk_val($sformatf("t3_solo_grant%0d", c), 32'(req_ready), 32'h4);
            tick();
            chk_val($sformatf("t3_solo_wr%0d", c), 32'({rf_wr_en, rf_wr_addr}), 32'hA);
        end
        req_valid = '0;
        tick();
        chk_val("t3_idle_wr_en", 32'(rf_wr_en), 32'h0);
        chk_val("t3_idle_data",  32'(rf_wr_data), 32'h32);

        // 4) RAW hazard on source 2
        do_reset();
        iss_valid = 1'b1; iss_addr = 3'd5;
        tick();
        iss_valid = 1'b0;
        chk_val("t4_pending", 32'(pending), 32'h20);
        iss_valid = 1'b1; iss_addr = 3'd0;
        chk_addr1 = 3'd0; chk_addr2 = 3'd5; chk_addr3 = 3'd0;
        chk_en = 3'b010;
        #1;
        chk_val("t4_hazard_en", 32'(chk_hazard), 32'h1);
        chk_val("t4_stall_en",  32'(iss_stall), 32'h1);
        chk_en = 3'b000;
        #1;
        chk_val("t4_hazard_off", 32'(chk_hazard), 32'h0);
        chk_val("t4_stall_off",  32'(iss_stall), 32'h0);
        chk_en = 3'b101;
        #1;
        chk_val("t4_hazard_src13", 32'(chk_hazard), 32'h0);
        chk_addr3 = 3'd5;
        #1;
        chk_val("t4_hazard_src3", 32'(chk_hazard), 32'h1);
        iss_valid = 1'b0;
        #1;
        chk_val("t4_stall_noiss", 32'(iss_stall), 32'h0);
        chk_en = 3'b000;
        chk_addr3 = 3'd0;

        // 5) WAW stall, then claim colliding with a clear of the same reg
        iss_valid = 1'b1; iss_addr = 3'd2;
        tick();
        chk_val("t5_pending_r2", 32'(pending), 32'h24);
        #1;
        chk_val("t5_waw_stall", 32'(iss_stall), 32'h1);
        tick();
        iss_valid = 1'b0;
        chk_val("t5_waw_nochg", 32'(pending), 32'h24);
        set_req(1, 3'd4, 8'h44);
        req_valid = 3'b010;
        tick();
        req_valid = '0;
        chk_val("t5_wr_r4", 32'({rf_wr_en, rf_wr_addr}), 32'hC);
        iss_valid = 1'b1; iss_addr = 3'd4;
        #1;
        chk_val("t5_claim_stall", 32'(iss_stall), 32'h0);
        tick();
        iss_valid = 1'b0;
        chk_val("t5_set_wins", 32'(pending), 32'h34);
        chk_val("t5_wb_err",   32'(wb_err), 32'h1);
        // claimed R4 written back: source on R4 still hazards while clearing
        req_valid = 3'b010;
        tick();
        req_valid = '0;
        chk_addr1 = 3'd4; chk_en = 3'b001;
        #1;
        chk_val("t5_nobypass", 32'(chk_hazard), 32'h1);
        tick();
        chk_val("t5_r4_clr",   32'(pending), 32'h24);
        chk_val("t5_hazard_gone", 32'(chk_hazard), 32'h0);
        chk_en = 3'b000;

        // 6) write-back to unclaimed R7
        do_reset();
        chk_val("t6_err_pre", 32'(wb_err), 32'h0);
        set_req(2, 3'd7, 8'h77);
        req_valid = 3'b100;
        tick();
        req_valid = '0;
        chk_val("t6_write", 32'({rf_wr_en, rf_wr_addr, rf_wr_data}), 32'hF77);
        chk_val("t6_err_set", 32'(wb_err), 32'h1);
        repeat (3) tick();
        chk_val("t6_err_sticky", 32'(wb_err), 32'h1);
        do_reset();
        chk_val("t6_err_rst", 32'(wb_err), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
